i2c_target_regs: RTL and testbench

- I2C target (responder) exposing the sensor register file, same byte-addressed data/addr interface as the sensor register block, to an external I2C initiator such as a flight computer or ground-support board.
- It is the opposite end of the I2C initiator drivers used for the altimeter and IMU.
- Standard 7-bit addressing, register pointer with auto-increment, read and write bursts.
- No clock stretching; SCL up to 400 kHz with clk at 50 MHz.

---
 rtl/i2c_target_regs.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register file: 7-bit address, auto-incrementing
// register pointer, read and write bursts, open-drain SDA, no clock stretching.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       busy,
    output logic       addr_hit
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] rx_byte;

    logic       sda_oe, oe_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_cnt, cnt_nxt;
    logic       byte_done, done_nxt;
    logic       rw, rw_nxt;
    logic [7:0] ptr_nxt, wd_nxt;
    logic       wr_en_nxt, hit_nxt, busy_nxt;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s & scl_prev;
    assign start_cond = ~sda_s & sda_prev & scl_s;
    assign stop_cond  = sda_s & ~sda_prev & scl_s;
    assign rx_byte    = {shift[6:0], sda_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            reg_addr  <= 8'h00;
            wr_data   <= 8'h00;
            wr_en     <= 1'b0;
            addr_hit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sda_oe    <= oe_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            byte_done <= done_nxt;
            rw        <= rw_nxt;
            reg_addr  <= ptr_nxt;
            wr_data   <= wd_nxt;
            wr_en     <= wr_en_nxt;
            addr_hit  <= hit_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        done_nxt  = byte_done;
        rw_nxt    = rw;
        ptr_nxt   = reg_addr;
        wd_nxt    = wr_data;
        wr_en_nxt = 1'b0;
        hit_nxt   = 1'b0;
        busy_nxt  = busy;

        // The pointer advances the clock after the write strobe so the strobe sees the old address.
        if (wr_en) ptr_nxt = reg_addr + 8'd1;

        // Bus conditions take priority over any SCL edge seen in the same clock.
        if (stop_cond) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else if (start_cond) begin
            state_nxt = ADDR;
            oe_nxt    = 1'b0;
            cnt_nxt   = 3'd0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt = rx_byte;
                        cnt_nxt   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            done_nxt = 1'b1;
                            if (state == PTR) ptr_nxt = rx_byte;
                            if (state == WR_DATA) begin
                                wd_nxt    = rx_byte;
                                wr_en_nxt = 1'b1;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        done_nxt = 1'b0;
                        if (state != ADDR) begin
                            oe_nxt    = 1'b1;
                            state_nxt = (state == PTR) ? PTR_ACK : WR_ACK;
                        end else if (shift[7:1] == DEV_ADDR) begin
                            oe_nxt    = 1'b1;
                            hit_nxt   = 1'b1;
                            busy_nxt  = 1'b1;
                            rw_nxt    = shift[0];
                            state_nxt = ADDR_ACK;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = 3'd0;
                        if (rw) begin
                            state_nxt = RD_DATA;
                            shift_nxt = reg_data;
                            oe_nxt    = ~reg_data[7];
                        end else begin
                            state_nxt = PTR;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt = WR_DATA;
                        oe_nxt    = 1'b0;
                        cnt_nxt   = 3'd0;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) done_nxt = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            done_nxt  = 1'b0;
                            oe_nxt    = 1'b0;
                            state_nxt = RD_ACK;
                        end else begin
                            shift_nxt = {shift[6:0], 1'b0};
                            oe_nxt    = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    // The pointer moves past every byte handed out; NACK parks us with busy held.
                    if (scl_rise) begin
                        ptr_nxt = reg_addr + 8'd1;
                        if (sda_s) state_nxt = IDLE;
                        else       done_nxt  = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        done_nxt  = 1'b0;
                        cnt_nxt   = 3'd0;
                        state_nxt = RD_DATA;
                        shift_nxt = reg_data;
                        oe_nxt    = ~reg_data[7];
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C initiator plus a transaction-level model
// of the register file and pointer.
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_line;
    logic [7:0] reg_addr, reg_data, wr_data;
    logic       wr_en, busy, addr_hit;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [7:0]  model_ptr = 8'h00;
    logic [15:0] wq[$];
    logic [15:0] wlog[$];
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    int          hp = 6;
    int          sd = 2;
    int          vectors = 0;
    int          errors = 0;
    int          hit_cnt = 0;
    logic        quiet = 1'b0;

    pullup (sda_line);
    assign sda_line = sda_low ? 1'b0 : 1'bz;
    assign reg_data = mem[reg_addr];

    i2c_target_regs dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl_drv),
        .sda      (sda_line),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (wr_en) mem[reg_addr] <= wr_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wlog.push_back({reg_addr, wr_data});
                if (wq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL wr_en_unexpected: got addr 0x%02h data 0x%02h, required no write",
                             reg_addr, wr_data);
                end else begin
                    chk("wr_en_write", {16'h0, reg_addr, wr_data}, {16'h0, wq.pop_front()});
                end
            end
            if (addr_hit) hit_cnt++;
            if (quiet) chk("quiet_bus", {29'h0, (!sda_low && !sda_line), busy, addr_hit}, 32'h0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        clks(sd);
        sda_low = ~b;
        clks(hp - sd);
        scl_drv = 1'b1;
        clks(hp / 2);
        r = sda_line;
        clks(hp - hp / 2);
        scl_drv = 1'b0;
    endtask

    task automatic start_c();
        clks(sd);
        sda_low = 1'b0;
        clks(hp - sd);
        scl_drv = 1'b1;
        clks(hp);
        sda_low = 1'b1;
        clks(hp);
        scl_drv = 1'b0;
    endtask

    task automatic stop_c();
        clks(sd);
        sda_low = 1'b1;
        clks(hp - sd);
        scl_drv = 1'b1;
        clks(hp);
        sda_low = 1'b0;
        clks(hp);
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic byte_r(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    // Addresses us for write, sets the pointer, then sends every byte queued in txq.
    task automatic wr_txn(input logic [7:0] ptr, input logic stop);
        logic       a;
        logic [7:0] d;
        int         h0;
        h0 = hit_cnt;
        start_c();
        byte_w({7'h42, 1'b0}, a);
        chk("ack_addr_w", a, 1);
        chk("addr_hit_w", hit_cnt - h0, 1);
        chk("busy_active", busy, 1);
        byte_w(ptr, a);
        chk("ack_ptr", a, 1);
        model_ptr = ptr;
        while (txq.size() != 0) begin
            d = txq.pop_front();
            wq.push_back({model_ptr, d});
            exp_mem[model_ptr] = d;
            model_ptr++;
            byte_w(d, a);
            chk("ack_data", a, 1);
        end
        if (stop) begin
            stop_c();
            chk("busy_after_stop", busy, 0);
        end
    endtask

    // Reads n bytes from the current pointer, NACKing the last one.
    task automatic rd_txn(input int n);
        logic       a;
        logic [7:0] d;
        start_c();
        byte_w({7'h42, 1'b1}, a);
        chk("ack_addr_r", a, 1);
        for (int i = 0; i < n; i++) begin
            byte_r(i == n - 1, d);
            chk("read_data", d, exp_mem[model_ptr]);
            model_ptr++;
            rxq.push_back(d);
        end
        chk("busy_after_nack", busy, 1);
        stop_c();
        chk("busy_after_stop", busy, 0);
        chk("ptr_after_read", reg_addr, model_ptr);
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic       a, r;
        logic [7:0] p;
        int         n, h0, bytes;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            exp_mem[i] = 8'(i) ^ 8'hA5;
        end
        clks(3);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr_hit", addr_hit, 0);
        chk("rst_sda", sda_line, 1);
        rst_n = 1'b1;
        clks(4);

        // Write pointer 0x10, repeated START, read three bytes.
        h0 = hit_cnt;
        rxq.delete();
        wr_txn(8'h10, 1'b0);
        rd_txn(3);
        chk("rs_read0", rxq[0], 8'hB5);
        chk("rs_read1", rxq[1], 8'hB4);
        chk("rs_read2", rxq[2], 8'hB7);
        chk("rs_ptr_end", reg_addr, 8'h13);
        chk("rs_hits", hit_cnt - h0, 2);

        // Burst write across the pointer wrap.
        wlog.delete();
        txq = '{8'h11, 8'h22, 8'h33};
        wr_txn(8'hFE, 1'b1);
        chk("burst_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("burst_w0", wlog[0], 16'hFE11);
            chk("burst_w1", wlog[1], 16'hFF22);
            chk("burst_w2", wlog[2], 16'h0033);
        end
        chk("burst_ptr_end", reg_addr, 8'h01);

        // Foreign address and general call must leave the bus and outputs untouched.
        quiet = 1'b1;
        start_c();
        byte_w(8'h86, a);
        chk("mismatch_ack", a, 0);
        for (int i = 0; i < 8; i++) begin
            byte_w(8'($urandom), a);
            chk("mismatch_data_ack", a, 0);
        end
        stop_c();
        start_c();
        byte_w(8'h00, a);
        chk("gencall_ack", a, 0);
        stop_c();
        quiet = 1'b0;
        chk("mismatch_ptr", reg_addr, 8'h01);

        // Abort mid-byte: pointer loaded, partial data byte discarded.
        start_c();
        byte_w(8'h84, a);
        byte_w(8'h20, a);
        model_ptr = 8'h20;
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
        stop_c();
        chk("abort_busy", busy, 0);
        chk("abort_ptr", reg_addr, 8'h20);
        rxq.delete();
        rd_txn(1);
        chk("abort_readback", rxq[0], 8'h85);

        // Reset while the target is driving a zero in the third read bit.
        txq = '{8'h00, 8'h5A};
        wr_txn(8'h40, 1'b1);
        wr_txn(8'h40, 1'b0);
        start_c();
        byte_w(8'h85, a);
        chk("rstread_ack", a, 1);
        bit_xfer(1'b1, r);
        bit_xfer(1'b1, r);
        clks(4);
        chk("rstread_driving", sda_line, 0);
        rst_n = 1'b0;
        #1;
        chk("rstread_sda", sda_line, 1);
        chk("rstread_ptr", reg_addr, 8'h00);
        chk("rstread_wr_data", wr_data, 8'h00);
        chk("rstread_busy", busy, 0);
        chk("rstread_wr_en", wr_en, 0);
        model_ptr = 8'h00;
        clks(2);
        scl_drv = 1'b1;
        sda_low = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(4);
        for (int i = 0; i < 2; i++) txq.push_back(8'($urandom));
        wr_txn(8'h55, 1'b1);
        wr_txn(8'h55, 1'b0);
        rd_txn(2);

        // 400 kHz SCL against 50 MHz clk, SDA moving 300 ns after SCL fall.
        hp = 62;
        sd = 15;
        p = 8'($urandom);
        for (int i = 0; i < 4; i++) txq.push_back(8'($urandom));
        wr_txn(p, 1'b0);
        rd_txn(4);
        hp = 6;
        sd = 2;

        // Random transactions.
        bytes = 0;
        while (bytes < 256) begin
            n = $urandom_range(1, 8);
            p = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
                    wr_txn(p, 1'b1);
                end
                1: begin
                    wr_txn(p, 1'b0);
                    rd_txn(n);
                end
                default: rd_txn(n);
            endcase
            chk("ptr_after_txn", reg_addr, model_ptr);
            bytes += n;
        end

        clks(4);
        chk("pending_writes", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
